inst_buffer_mw: RTL
===================

Name: inst_buffer_mw

Overview:
- Parametrised successor to the frontend instruction buffer, sitting between predecode and the backend decode stage.
- Accepts up to FETCH_WIDTH predecoded instructions per cycle and compacts the valid lanes into a circular buffer.
- Delivers up to DECODE_WIDTH instructions per cycle through a registered output stage.
- Supports backend stall and frontend redirect flush. The previous generation had a fixed width and no lane compaction.

Parameters:
- FETCH_WIDTH, 8, input lanes per fetch block.
- DECODE_WIDTH, 4, output lanes per cycle. Must satisfy DECODE_WIDTH ≤ FETCH_WIDTH.
- DEPTH, 32, number of storage entries. Power of 2, and DEPTH ≥ 2*FETCH_WIDTH.
- INST_W, 32, instruction width in bits.
- META_W, 8, per-instruction metadata width (fsq index/offset tag).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch block present.
- in_mask  in  FETCH_WIDTH  per-lane valid mask.
- in_inst  in  FETCH_WIDTH*INST_W  lane-packed instructions; lane i occupies bits [i*INST_W +: INST_W].
- in_meta  in  FETCH_WIDTH*META_W  lane-packed metadata.
- full  out  1  buffer cannot accept a full fetch block.
- redirect  in  1  flush request from fsq/backend.
- stall  in  1  backend cannot accept output this cycle.
- out_valid  out  DECODE_WIDTH  contiguous valid lanes starting at lane 0.
- out_inst  out  DECODE_WIDTH*INST_W  output instructions.
- out_meta  out  DECODE_WIDTH*META_W  output metadata.
- count  out  $clog2(DEPTH)+1  occupied storage entries (output register not included).

Behaviour:
- Reset: head=0, tail=0, count=0, full=0, out_valid=0. out_inst and out_meta reset to 0.
- Pointers are $clog2(DEPTH)+1 bits wide and carry a wrap bit. Index = low bits; empty when head==tail; wrap is natural modulo DEPTH.
- Enqueue fires when in_valid && !full && !redirect.
  - Lanes with in_mask[i]=1 are written in ascending lane order to slots tail, tail+1, …
  - tail advances by popcount(in_mask).
  - in_mask=0 is accepted and writes nothing.
- Input ignored while full=1. The upstream stage holds its data; nothing is written.
- Output stage:
  - When !stall && !redirect, the output registers load n = min(count, DECODE_WIDTH) entries from head.
  - Set out_valid = (1<<n)-1; head += n.
  - When stall=1, the output registers and head hold, even if out_valid=0.
- Output lane contents are don't-care where out_valid=0, except after reset.
- Latency: an instruction enqueued in cycle N appears on the outputs at cycle N+2 at the earliest, assuming no stall and no older entries.
- Simultaneous enqueue and dequeue in one cycle: count_next = count + popcount(in_mask if enqueue fires) − n.
- full is registered: full ← (count_next > DEPTH − FETCH_WIDTH).
- count never exceeds DEPTH. Enqueue while full is impossible by construction; it is an assertion in verification.
- Redirect has priority over everything:
  - Next cycle: head=tail=0, count=0, full=0, out_valid=0.
  - Same-cycle input is dropped and stall is ignored.
- Redirect held for multiple cycles keeps the buffer empty.
- Reset asserted mid-operation returns all state to reset values asynchronously, with no partial writes.
- DECODE_WIDTH < FETCH_WIDTH: a full fetch block drains over ceil(popcount/DECODE_WIDTH) cycles.

Optional Feature:
- Macro: IBUF_BYPASS_EN.
- Defined:
  - Condition: count==0, !stall, no redirect, and enqueue fires.
  - The output registers load the first min(popcount, DECODE_WIDTH) compacted input lanes directly.
  - Only the remainder is written to storage, so latency becomes N+1.
  - count and full account only for entries written to storage.
- Undefined: no bypass path; latency is always ≥ 2 cycles.

Test Plan:
- Reset, then in_valid=1, in_mask=8'hFF, inst=0..7, no stall.
  - Cycle+2: out_valid=4'hF, inst 0..3.
  - Cycle+3: inst 4..7.
  - Then out_valid=0 and count=0.
- in_mask=8'b1010_0101, inst lanes = lane index.
  - Output lanes carry 0,2,5,7 in order.
  - count peaks at 4.
- Hold stall=1 and enqueue full blocks until full.
  - full rises once count > 24, i.e. after 4 blocks (count=32).
  - Further in_valid is ignored and count stays 32.
- Wrap: enqueue/dequeue 40 blocks continuously with mixed masks.
  - Output order matches the input order exactly across pointer wrap.
- Redirect with count=20, stall=1, and a same-cycle enqueue.
  - Next cycle: count=0, out_valid=0, full=0.
  - The dropped block never appears on the outputs.
- With IBUF_BYPASS_EN on an empty buffer, enqueue 8'h0F.
  - Inst visible at cycle+1 and count stays 0.
- Without IBUF_BYPASS_EN, the same stimulus is visible at cycle+2.

Source files
------------

// File: rtl/inst_buffer_mw.sv
// Multi-width instruction buffer: compacts masked fetch lanes into a circular store and
// issues up to DECODE_WIDTH per cycle from a registered output stage. `IBUF_BYPASS_EN adds an empty-buffer bypass.
module inst_buffer_mw #(
    parameter int FETCH_WIDTH  = 8,
    parameter int DECODE_WIDTH = 4,
    parameter int DEPTH        = 32,
    parameter int INST_W       = 32,
    parameter int META_W       = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [FETCH_WIDTH-1:0]         in_mask,
    input  logic [FETCH_WIDTH*INST_W-1:0]  in_inst,
    input  logic [FETCH_WIDTH*META_W-1:0]  in_meta,
    output logic                           full,
    input  logic                           redirect,
    input  logic                           stall,
    output logic [DECODE_WIDTH-1:0]        out_valid,
    output logic [DECODE_WIDTH*INST_W-1:0] out_inst,
    output logic [DECODE_WIDTH*META_W-1:0] out_meta,
    output logic [$clog2(DEPTH):0]         count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]               head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic                           full_q, full_d;
    logic [DECODE_WIDTH-1:0]        out_valid_q, out_valid_d;
    logic [DECODE_WIDTH*INST_W-1:0] out_inst_q, out_inst_d;
    logic [DECODE_WIDTH*META_W-1:0] out_meta_q, out_meta_d;

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [META_W-1:0] meta_mem [DEPTH];

    logic                           enq, byp;
    logic [PTR_W-1:0]               in_pop, n_deq, n_byp, n_store;
    logic [PTR_W-1:0]               lane_off [FETCH_WIDTH];
    logic [PTR_W-1:0]               wr_slot  [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0]         wr_en;
    logic [DECODE_WIDTH*INST_W-1:0] byp_inst;
    logic [DECODE_WIDTH*META_W-1:0] byp_meta;

    function automatic logic [PTR_W-1:0] cap_dw(input logic [PTR_W-1:0] n);
        return (n > PTR_W'(DECODE_WIDTH)) ? PTR_W'(DECODE_WIDTH) : n;
    endfunction

    function automatic logic [DECODE_WIDTH-1:0] therm(input logic [PTR_W-1:0] n);
        logic [DECODE_WIDTH-1:0] m;
        m = '0;
        for (int k = 0; k < DECODE_WIDTH; k++) m[k] = (PTR_W'(k) < n);
        return m;
    endfunction

    // Exclusive prefix popcount gives each valid lane its compacted position.
    always_comb begin
        in_pop = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            lane_off[i] = in_pop;
            in_pop      = in_pop + PTR_W'(in_mask[i]);
        end
    end

    assign enq   = in_valid && !full_q && !redirect;
    assign n_deq = (stall || redirect) ? '0 : cap_dw(count_q);

`ifdef IBUF_BYPASS_EN
    assign byp   = enq && (count_q == '0) && !stall;
    assign n_byp = byp ? cap_dw(in_pop) : '0;

    always_comb begin
        byp_inst = '0;
        byp_meta = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            for (int k = 0; k < DECODE_WIDTH; k++) begin
                if (in_mask[i] && lane_off[i] == PTR_W'(k)) begin
                    byp_inst[k*INST_W +: INST_W] = in_inst[i*INST_W +: INST_W];
                    byp_meta[k*META_W +: META_W] = in_meta[i*META_W +: META_W];
                end
            end
        end
        // Lanes already routed to the output register are not stored.
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            wr_en[i]   = enq && in_mask[i] && (lane_off[i] >= n_byp);
            wr_slot[i] = tail_q + lane_off[i] - n_byp;
        end
    end
`else
    assign byp      = 1'b0;
    assign n_byp    = '0;
    assign byp_inst = '0;
    assign byp_meta = '0;

    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            wr_en[i]   = enq && in_mask[i];
            wr_slot[i] = tail_q + lane_off[i];
        end
    end
`endif

    assign n_store = enq ? (in_pop - n_byp) : '0;

    always_comb begin
        head_d      = head_q + n_deq;
        tail_d      = tail_q + n_store;
        count_d     = count_q + n_store - n_deq;
        full_d      = (count_d > PTR_W'(DEPTH - FETCH_WIDTH));
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_meta_d  = out_meta_q;
        if (redirect) begin
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            full_d      = 1'b0;
            out_valid_d = '0;
        end else if (!stall) begin
            if (byp) begin
                out_valid_d = therm(n_byp);
                out_inst_d  = byp_inst;
                out_meta_d  = byp_meta;
            end else begin
                out_valid_d = therm(n_deq);
                for (int k = 0; k < DECODE_WIDTH; k++) begin
                    out_inst_d[k*INST_W +: INST_W] = inst_mem[IDX_W'(head_q + PTR_W'(k))];
                    out_meta_d[k*META_W +: META_W] = meta_mem[IDX_W'(head_q + PTR_W'(k))];
                end
            end
        end
    end

    // Storage array: contents only meaningful between head and tail, so no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (wr_en[i]) begin
                inst_mem[IDX_W'(wr_slot[i])] <= in_inst[i*INST_W +: INST_W];
                meta_mem[IDX_W'(wr_slot[i])] <= in_meta[i*META_W +: META_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            out_valid_q <= '0;
            out_inst_q  <= '0;
            out_meta_q  <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_meta_q  <= out_meta_d;
        end
    end

    assign full      = full_q;
    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign out_meta  = out_meta_q;
    assign count     = count_q;

endmodule
